// File: rtl/rv32_if_top.sv
// RV32I instruction-fetch stage: owns fetch PC, feeds ID, handles redirect/stall/halt.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module rv32_if_top #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_IW    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_IW = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  input  logic        jump_enable_in,
  input  logic [31:0] jump_addr_in,
  input  logic        pc_stop_in,
  output logic [31:0] pc_out,
  output logic [31:0] iw_out,
  output logic        halted_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_squash_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] pc_out_next;
  logic        valid_q, valid_q_next;
  logic [31:0] iw_hold, iw_hold_next;
  logic        halted_next;

  logic        do_advance;
  logic        do_jump;
  logic        is_ebreak;
  logic [31:0] jump_target;

  // Misaligned targets are silently word-aligned; no trap is raised.
  assign jump_target = jump_addr_in & 32'hFFFF_FFFC;
  assign imem_addr   = fetch_pc;
  assign is_ebreak   = (iw_out == EBREAK_IW);

  always_comb begin
    if (state == HALT)
      iw_out = NOP_IW;
    else if (state == STALL)
      iw_out = iw_hold;
    else if (valid_q)
      iw_out = imem_rd_data;
    else
      iw_out = NOP_IW;
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    pc_out_next   = pc_out;
    valid_q_next  = valid_q;
    iw_hold_next  = iw_hold;
    halted_next   = halted_out;
    do_advance    = 1'b0;
    do_jump       = 1'b0;

    // Priority inside RUN/STALL: EBREAK > jump > stall > advance.
    case (state)
      FILL: begin
        do_advance = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (is_ebreak) begin
          state_next  = HALT;
          halted_next = 1'b1;
        end else if (jump_enable_in) begin
          do_jump = 1'b1;
        end else if (pc_stop_in) begin
          iw_hold_next = iw_out;
          state_next   = STALL;
        end else begin
          do_advance = 1'b1;
        end
      end
      STALL: begin
        if (is_ebreak) begin
          state_next  = HALT;
          halted_next = 1'b1;
        end else if (jump_enable_in) begin
          do_jump    = 1'b1;
          state_next = RUN;
        end else if (!pc_stop_in) begin
          // Memory kept re-reading fetch_pc while stalled, so its data is current.
          do_advance = 1'b1;
          state_next = RUN;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = FILL;
      end
    endcase

    if (do_advance) begin
      pc_out_next   = fetch_pc;
      fetch_pc_next = fetch_pc + 32'd4;
      valid_q_next  = 1'b1;
    end else if (do_jump) begin
      fetch_pc_next = jump_target;
      valid_q_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      fetch_pc   <= RESET_PC;
      pc_out     <= RESET_PC;
      valid_q    <= 1'b0;
      iw_hold    <= NOP_IW;
      halted_out <= 1'b0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      pc_out     <= pc_out_next;
      valid_q    <= valid_q_next;
      iw_hold    <= iw_hold_next;
      halted_out <= halted_next;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Counter order: 0 = fetch, 1 = squash, 2 = stall. None can step while halted.
  logic [2:0]  perf_inc;
  logic [31:0] perf_cnt [3];

  assign perf_inc[0] = do_advance;
  assign perf_inc[1] = do_jump;
  assign perf_inc[2] = (state == STALL);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      always_ff @(posedge clk) begin
        if (reset)
          perf_cnt[gi] <= 32'd0;
        else if (perf_inc[gi])
          perf_cnt[gi] <= perf_cnt[gi] + 32'd1;
      end
    end
  endgenerate

  assign perf_fetch_cnt  = perf_cnt[0];
  assign perf_squash_cnt = perf_cnt[1];
  assign perf_stall_cnt  = perf_cnt[2];
`endif

endmodule

// File: tb/tb_rv32_if_top.sv
// Directed-vector bench for rv32_if_top with a synchronous-read instruction memory model.
module tb_rv32_if_top;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic        jump_enable_in;
  logic [31:0] jump_addr_in;
  logic        pc_stop_in;
  logic [31:0] pc_out;
  logic [31:0] iw_out;
  logic        halted_out;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_squash_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  always @(posedge clk) imem_rd_data <= mem[imem_addr[9:2]];

  rv32_if_top dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .jump_enable_in (jump_enable_in),
    .jump_addr_in   (jump_addr_in),
    .pc_stop_in     (pc_stop_in),
    .pc_out         (pc_out),
    .iw_out         (iw_out),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_squash_cnt(perf_squash_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .halted_out     (halted_out)
  );

  // Memory image: word i holds addi x0,x0,i so every word is distinct.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ({24'd0, a[9:2]} << 20) | 32'h13;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_slot(input string tag, input logic [31:0] pc,
                             input logic [31:0] iw, input logic [31:0] addr);
    check({tag, ".pc"},   pc_out,    pc);
    check({tag, ".iw"},   iw_out,    iw);
    check({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) << 20) | 32'h13;
    reset          = 1'b1;
    jump_enable_in = 1'b0;
    jump_addr_in   = 32'h0;
    pc_stop_in     = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Reset / fill
    expect_slot("fill", 32'h0, NOP, 32'h0);
    check("fill.halted", {31'd0, halted_out}, 32'd0);
`ifdef IF_PERF_CNT_EN
    check("perf.rst.fetch", perf_fetch_cnt, 32'd0);
    check("perf.rst.stall", perf_stall_cnt, 32'd0);
`endif
    step(); expect_slot("run0", 32'h0, word_at(32'h0), 32'h4);
    step(); expect_slot("run4", 32'h4, word_at(32'h4), 32'h8);
    step(); expect_slot("run8", 32'h8, word_at(32'h8), 32'hC);

    // Jump from pc_out=8 to 0x40
    jump_enable_in = 1'b1; jump_addr_in = 32'h40;
    step(); expect_slot("jmp.sq", 32'h8, NOP, 32'h40);
    jump_enable_in = 1'b0;
    step(); expect_slot("jmp.tgt", 32'h40, word_at(32'h40), 32'h44);
`ifdef IF_PERF_CNT_EN
    check("perf.fetch", perf_fetch_cnt, 32'd4);
    check("perf.squash", perf_squash_cnt, 32'd1);
    check("perf.stall0", perf_stall_cnt, 32'd0);
`endif

    // Redirect to 0x10, then stall there for three cycles
    jump_enable_in = 1'b1; jump_addr_in = 32'h10;
    step(); expect_slot("j10.sq", 32'h40, NOP, 32'h10);
    jump_enable_in = 1'b0;
    step(); expect_slot("j10.tgt", 32'h10, word_at(32'h10), 32'h14);
    pc_stop_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); expect_slot($sformatf("stall%0d", k), 32'h10, word_at(32'h10), 32'h14);
    end
    pc_stop_in = 1'b0;
`ifdef IF_PERF_CNT_EN
    check("perf.stall2", perf_stall_cnt, 32'd2);
`endif
    step(); expect_slot("unst14", 32'h14, word_at(32'h14), 32'h18);

    // Jump with stall during STALL, misaligned target 0x103
    pc_stop_in = 1'b1;
    step(); expect_slot("st.hold", 32'h14, word_at(32'h14), 32'h18);
    jump_enable_in = 1'b1; jump_addr_in = 32'h103;
    step(); expect_slot("stj.sq", 32'h14, NOP, 32'h100);
    jump_enable_in = 1'b0; pc_stop_in = 1'b0;
    step(); expect_slot("stj.tgt", 32'h100, word_at(32'h100), 32'h104);

    // Fetch-PC wrap past 2^32
    jump_enable_in = 1'b1; jump_addr_in = 32'hFFFF_FFFE;
    step(); expect_slot("wrap.sq", 32'h100, NOP, 32'hFFFF_FFFC);
    jump_enable_in = 1'b0;
    step(); expect_slot("wrap.top", 32'hFFFF_FFFC, word_at(32'hFFFF_FFFC), 32'h0);
    step(); expect_slot("wrap.zero", 32'h0, word_at(32'h0), 32'h4);

    // EBREAK at word 0x0C, with a simultaneous jump that must be ignored
    reset = 1'b1;
    mem[3] = EBRK;
    step();
    reset = 1'b0;
    expect_slot("eb.fill", 32'h0, NOP, 32'h0);
    step(); step(); step();
    expect_slot("eb.pre", 32'h8, word_at(32'h8), 32'hC);
    step(); expect_slot("eb.iw", 32'hC, EBRK, 32'h10);
    check("eb.halted0", {31'd0, halted_out}, 32'd0);
    jump_enable_in = 1'b1; jump_addr_in = 32'h80;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_slot($sformatf("halt%0d", k), 32'hC, NOP, 32'h10);
      check($sformatf("halt%0d.flag", k), {31'd0, halted_out}, 32'd1);
      jump_enable_in = ~jump_enable_in;
    end
    jump_enable_in = 1'b0;

    // Reset out of HALT
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_slot("rst.halt", 32'h0, NOP, 32'h0);
    check("rst.halted", {31'd0, halted_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
